// File: rtl/midi_if.sv
// MIDI synth board-boundary signals: serial MIDI input and square-wave audio output.
interface midi_if;
   logic uart_rx;
   logic audio_pwm;

   modport master (output uart_rx, input audio_pwm);
   modport slave  (input uart_rx, output audio_pwm);
endinterface

// File: rtl/midi_top.sv
// Monophonic MIDI-to-square-wave synthesizer: UART RX, Note On/Off parser, pitch table, tone generator.
// Optional macro MIDI_RUNNING_STATUS_EN keeps the stored status after a completed message.
module midi_top #(
   parameter int CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE  = 9600
) (
   input logic clk,
   input logic reset,
   midi_if.slave midi
);
   localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_HIGH = 3'd4;

   function automatic logic [22:0] half_of(input real freq);
      real h;
      h = real'(CLOCK_FREQ) / (2.0 * freq);
      return 23'($rtoi(h + 0.5));
   endfunction

   // Lowest octave (MIDI notes 0..11); higher octaves are right shifts of these.
   localparam logic [22:0] HALF0  = half_of(8.175798915643707);
   localparam logic [22:0] HALF1  = half_of(8.661957218027252);
   localparam logic [22:0] HALF2  = half_of(9.177023997418988);
   localparam logic [22:0] HALF3  = half_of(9.722718241315029);
   localparam logic [22:0] HALF4  = half_of(10.300861153527183);
   localparam logic [22:0] HALF5  = half_of(10.913382232281373);
   localparam logic [22:0] HALF6  = half_of(11.562325709738575);
   localparam logic [22:0] HALF7  = half_of(12.249857374429663);
   localparam logic [22:0] HALF8  = half_of(12.978271799373287);
   localparam logic [22:0] HALF9  = half_of(13.75);
   localparam logic [22:0] HALF10 = half_of(14.567617547440307);
   localparam logic [22:0] HALF11 = half_of(15.433853164253883);

   logic             rx_meta, rx_sync;
   logic [2:0]       rx_state;
   logic [CNT_W-1:0] bit_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;
   logic             byte_vld;

   // Sync stage: reset to idle-high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= midi.uart_rx;
         rx_sync <= rx_meta;
      end
   end

   // Receiver stage
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state <= S_IDLE;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         byte_vld <= 1'b0;
      end else begin
         byte_vld <= 1'b0;
         case (rx_state)
            S_IDLE: begin
               bit_cnt <= '0;
               if (!rx_sync) rx_state <= S_START;
            end
            S_START: begin
               if (bit_cnt == CNT_W'(HALF_BIT - 1)) begin
                  bit_cnt  <= '0;
                  bit_idx  <= '0;
                  rx_state <= rx_sync ? S_IDLE : S_DATA;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (bit_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                  bit_cnt   <= '0;
                  shift_reg <= {rx_sync, shift_reg[7:1]};
                  if (bit_idx == 3'd7) rx_state <= S_STOP;
                  else                 bit_idx  <= bit_idx + 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (bit_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                  bit_cnt <= '0;
                  if (rx_sync) begin
                     byte_vld <= 1'b1;
                     rx_state <= S_IDLE;
                  end else begin
                     rx_state <= S_WAIT_HIGH;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_WAIT_HIGH: if (rx_sync) rx_state <= S_IDLE;
            default:     rx_state <= S_IDLE;
         endcase
      end
   end

   logic       status_vld, status_on, data_idx;
   logic [6:0] note_byte, cur_note;
   logic       gate, note_start;

   // Parser and note stage
   always_ff @(posedge clk) begin
      if (reset) begin
         status_vld <= 1'b0;
         status_on  <= 1'b0;
         data_idx   <= 1'b0;
         cur_note   <= '0;
         gate       <= 1'b0;
         note_start <= 1'b0;
      end else begin
         note_start <= 1'b0;
         if (byte_vld) begin
            if (shift_reg[7]) begin
               status_vld <= (shift_reg[7:5] == 3'b100);
               status_on  <= shift_reg[4];
               data_idx   <= 1'b0;
            end else if (status_vld) begin
               if (!data_idx) begin
                  note_byte <= shift_reg[6:0];
                  data_idx  <= 1'b1;
               end else begin
                  data_idx <= 1'b0;
`ifndef MIDI_RUNNING_STATUS_EN
                  status_vld <= 1'b0;
`endif
                  if (status_on && shift_reg[6:0] != 7'd0) begin
                     cur_note   <= note_byte;
                     gate       <= 1'b1;
                     note_start <= 1'b1;
                  end else if (note_byte == cur_note) begin
                     gate <= 1'b0;
                  end
               end
            end
         end
      end
   end

   logic [3:0]  note_mod, note_oct;
   logic [22:0] half_base, half_period, tone_cnt;

   always_comb begin
      note_mod  = 4'(cur_note % 7'd12);
      note_oct  = 4'(cur_note / 7'd12);
      half_base = HALF0;
      case (note_mod)
         4'd1:    half_base = HALF1;
         4'd2:    half_base = HALF2;
         4'd3:    half_base = HALF3;
         4'd4:    half_base = HALF4;
         4'd5:    half_base = HALF5;
         4'd6:    half_base = HALF6;
         4'd7:    half_base = HALF7;
         4'd8:    half_base = HALF8;
         4'd9:    half_base = HALF9;
         4'd10:   half_base = HALF10;
         4'd11:   half_base = HALF11;
         default: half_base = HALF0;
      endcase
      half_period = half_base >> note_oct;
   end

   // Tone stage: a (re)triggered note always starts with a fresh high half-period.
   always_ff @(posedge clk) begin
      if (reset) begin
         tone_cnt       <= '0;
         midi.audio_pwm <= 1'b0;
      end else if (note_start) begin
         tone_cnt       <= '0;
         midi.audio_pwm <= 1'b1;
      end else if (gate) begin
         if (tone_cnt == half_period - 23'd1) begin
            tone_cnt       <= '0;
            midi.audio_pwm <= ~midi.audio_pwm;
         end else begin
            tone_cnt <= tone_cnt + 1'b1;
         end
      end else begin
         tone_cnt       <= '0;
         midi.audio_pwm <= 1'b0;
      end
   end
endmodule

// File: tb/tb_midi_top.sv
// Randomized self-checking bench for midi_top against a behavioural MIDI/pitch reference model.
module tb_midi_top;
   localparam int CF  = 500_000;
   localparam int BR  = 50_000;
   localparam int CPB = CF / BR;
   localparam int LIM = 12000;

   logic clk = 1'b0;
   logic reset;
   midi_if mif ();

   midi_top #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
      .clk   (clk),
      .reset (reset),
      .midi  (mif.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit       m_status_vld = 0;
   bit [7:0] m_status     = 0;
   int       m_idx        = 0;
   int       m_note_byte  = 0;
   int       m_note       = 0;
   bit       m_gate       = 0;

   function automatic int exp_half(input int n);
      real f;
      int  base;
      f    = 440.0 * (2.0 ** ((real'(n % 12) - 69.0) / 12.0));
      base = $rtoi(real'(CF) / (2.0 * f) + 0.5);
      return base >> (n / 12);
   endfunction

   task automatic model_byte(input logic [7:0] b);
      if (b >= 8'h80) begin
         m_status_vld = (b >= 8'h80 && b <= 8'h9F);
         m_status     = b;
         m_idx        = 0;
      end else if (m_status_vld) begin
         if (m_idx == 0) begin
            m_note_byte = int'(b);
            m_idx       = 1;
         end else begin
            m_idx = 0;
`ifndef MIDI_RUNNING_STATUS_EN
            m_status_vld = 0;
`endif
            if (m_status >= 8'h90 && b != 0) begin
               m_note = m_note_byte;
               m_gate = 1;
            end else if (m_note_byte == m_note) begin
               m_gate = 0;
            end
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      @(negedge clk);
      mif.uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         mif.uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      mif.uart_rx = stop_ok;
      repeat (CPB) @(negedge clk);
      mif.uart_rx = 1'b1;
      repeat (stop_ok ? 2 : CPB) @(negedge clk);
      if (stop_ok) model_byte(b);
   endtask

   task automatic send_msg(input logic [7:0] s, input logic [7:0] n, input logic [7:0] v);
      send_byte(s, 1'b1);
      send_byte(n, 1'b1);
      send_byte(v, 1'b1);
   endtask

   // Measures one complete low phase followed by one complete high phase.
   task automatic measure(output int lo, output int hi, output bit ok);
      int t;
      ok = 1; lo = 0; hi = 0; t = 0;
      while (mif.audio_pwm !== 1'b1 && t < LIM) begin @(negedge clk); t++; end
      while (mif.audio_pwm !== 1'b0 && t < LIM) begin @(negedge clk); t++; end
      while (mif.audio_pwm === 1'b0 && t < LIM) begin @(negedge clk); t++; lo++; end
      while (mif.audio_pwm === 1'b1 && t < LIM) begin @(negedge clk); t++; hi++; end
      if (t >= LIM) ok = 0;
   endtask

   task automatic watch_silent(input int n, output int highs);
      highs = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (mif.audio_pwm !== 1'b0) highs++;
      end
   endtask

   task automatic test_reset();
      int highs;
      reset = 1'b1;
      mif.uart_rx = 1'b1;
      watch_silent(2 * CPB, highs);
      reset = 1'b0;
      m_status_vld = 0; m_idx = 0; m_note = 0; m_gate = 0;
      checks++;
      if (highs != 0) begin
         errors++; $display("FAIL reset_hold: audio high %0d cycles, required 0", highs);
      end
      watch_silent(4 * CPB, highs);
      checks++;
      if (highs != 0) begin
         errors++; $display("FAIL reset_idle: audio high %0d cycles, required 0", highs);
      end
   endtask

   task automatic test_note_on_off();
      int lo, hi, highs; bit ok;
      send_msg(8'h90, 8'h3C, 8'h7F);
      checks++;
      if (mif.audio_pwm !== 1'b1) begin
         errors++; $display("FAIL note_on_start_high: audio %b, required 1", mif.audio_pwm);
      end
      measure(lo, hi, ok);
      checks++;
      if (!ok || lo != exp_half(m_note) || hi != exp_half(m_note)) begin
         errors++; $display("FAIL note_on_3c: lo %0d hi %0d ok %0d, required %0d", lo, hi, ok, exp_half(m_note));
      end
      send_msg(8'h80, 8'h3C, 8'h7F);
      checks++;
      if (mif.audio_pwm !== 1'b0) begin
         errors++; $display("FAIL note_off_now: audio %b, required 0", mif.audio_pwm);
      end
      watch_silent(2500, highs);
      checks++;
      if (highs != 0) begin
         errors++; $display("FAIL note_off_stay: audio high %0d cycles, required 0", highs);
      end
   endtask

   task automatic test_two_notes();
      int lo, hi, highs; bit ok;
      send_msg(8'h91, 8'h40, 8'h7F);
      measure(lo, hi, ok);
      checks++;
      if (!ok || lo != exp_half(m_note) || hi != exp_half(m_note)) begin
         errors++; $display("FAIL note_40: lo %0d hi %0d ok %0d, required %0d", lo, hi, ok, exp_half(m_note));
      end
      send_msg(8'h91, 8'h43, 8'h7F);
      checks++;
      if (mif.audio_pwm !== 1'b1) begin
         errors++; $display("FAIL note_43_start_high: audio %b, required 1", mif.audio_pwm);
      end
      measure(lo, hi, ok);
      checks++;
      if (!ok || lo != exp_half(m_note) || hi != exp_half(m_note)) begin
         errors++; $display("FAIL note_43: lo %0d hi %0d ok %0d, required %0d", lo, hi, ok, exp_half(m_note));
      end
      send_msg(8'h81, 8'h40, 8'h40);
      measure(lo, hi, ok);
      checks++;
      if (!ok || lo != exp_half(m_note) || hi != exp_half(m_note)) begin
         errors++; $display("FAIL off_other_note: lo %0d hi %0d ok %0d, required %0d", lo, hi, ok, exp_half(m_note));
      end
      send_msg(8'h81, 8'h43, 8'h40);
      watch_silent(2500, highs);
      checks++;
      if (highs != 0) begin
         errors++; $display("FAIL off_current_note: audio high %0d cycles, required 0", highs);
      end
   endtask

   task automatic test_velocity_zero();
      int highs;
      send_msg(8'h90, 8'h3C, 8'h7F);
      send_msg(8'h90, 8'h3C, 8'h00);
      watch_silent(2500, highs);
      checks++;
      if (highs != 0) begin
         errors++; $display("FAIL velocity_zero: audio high %0d cycles, required 0", highs);
      end
   endtask

   task automatic test_framing_error();
      int lo, hi, highs; bit ok;
      send_byte(8'h90, 1'b0);
      send_byte(8'h48, 1'b1);
      send_byte(8'h7F, 1'b1);
      watch_silent(500, highs);
      checks++;
      if (highs != 0) begin
         errors++; $display("FAIL framing_dropped: audio high %0d cycles, required 0", highs);
      end
      send_msg(8'h9F, 8'(m_note == 60 ? 62 : 60), 8'h33);
      measure(lo, hi, ok);
      checks++;
      if (!ok || lo != exp_half(m_note) || hi != exp_half(m_note)) begin
         errors++; $display("FAIL after_framing: lo %0d hi %0d ok %0d, required %0d", lo, hi, ok, exp_half(m_note));
      end
      send_msg(8'h8F, 8'(m_note), 8'h00);
   endtask

   task automatic test_status_filter();
      int lo, hi, highs; bit ok;
      send_msg(8'hB0, 8'h3C, 8'h7F);
      watch_silent(500, highs);
      checks++;
      if (highs != 0) begin
         errors++; $display("FAIL other_status: audio high %0d cycles, required 0", highs);
      end
      send_byte(8'h90, 1'b1);
      send_byte(8'h3C, 1'b1);
      send_msg(8'h92, 8'h45, 8'h20);
      measure(lo, hi, ok);
      checks++;
      if (!ok || lo != exp_half(m_note) || hi != exp_half(m_note)) begin
         errors++; $display("FAIL mid_msg_status: lo %0d hi %0d ok %0d, required %0d", lo, hi, ok, exp_half(m_note));
      end
      send_msg(8'h82, 8'h45, 8'h00);
   endtask

   task automatic test_running_status();
      int lo, hi, want; bit ok;
      send_msg(8'h90, 8'h3C, 8'h7F);
      send_byte(8'h40, 1'b1);
      send_byte(8'h7F, 1'b1);
`ifdef MIDI_RUNNING_STATUS_EN
      want = exp_half(8'h40);
`else
      want = exp_half(8'h3C);
`endif
      measure(lo, hi, ok);
      checks++;
      if (!ok || lo != want || hi != want) begin
         errors++; $display("FAIL running_status: lo %0d hi %0d ok %0d, required %0d", lo, hi, ok, want);
      end
   endtask

   task automatic test_random();
      int lo, hi, highs; bit ok;
      logic [7:0] n;
      for (int i = 0; i < 5; i++) begin
         if ($urandom_range(1, 0) == 1)
            send_msg(8'($urandom_range(8'hEF, 8'hA0)), 8'($urandom_range(127, 0)), 8'h7F);
         n = 8'($urandom_range(100, 55));
         send_msg(8'h90 | 8'($urandom_range(15, 0)), n, 8'($urandom_range(127, 1)));
         send_msg(8'h80 | 8'($urandom_range(15, 0)), n ^ 8'h01, 8'h00);
         measure(lo, hi, ok);
         checks++;
         if (!ok || lo != exp_half(m_note) || hi != exp_half(m_note)) begin
            errors++; $display("FAIL random_note_%0d: note %0d lo %0d hi %0d ok %0d, required %0d", i, m_note, lo, hi, ok, exp_half(m_note));
         end
      end
      send_msg(8'h85, 8'(m_note), 8'h10);
      watch_silent(2000, highs);
      checks++;
      if (highs != 0) begin
         errors++; $display("FAIL random_release: audio high %0d cycles, required 0", highs);
      end
   endtask

   initial begin
      test_reset();
      test_note_on_off();
      test_two_notes();
      test_velocity_zero();
      test_framing_error();
      test_status_filter();
      test_running_status();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
